stream_reframer: RTL and testbench
==================================

Name: stream_reframer

Overview:
- Downstream counterpart to the sample-delay adjuster in the gmrr stream chain. The adjuster inserts and drops samples and does not preserve packet boundaries.
- This block rebuilds AXI-Stream framing: it asserts tlast every max_spp samples and, optionally, at upstream tlast.
- Optionally holds the newest sample so that a partial packet can be closed with tlast after the input goes idle.
- Sits directly after the delay adjuster, before packetization into CHDR.

Parameters:
- MAX_LEN_LOG2, 10, width of max_spp and of the in-packet sample counter.
- WIDTH, 16, sample data width.
- TIMEOUT_LOG2, 8, width of idle_timeout and of the idle counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush; same effect as reset
- max_spp  in  MAX_LEN_LOG2  maximum samples per output packet; 0 is treated as 1
- honor_tlast  in  1  when 1, upstream i_tlast also ends a packet
- idle_timeout  in  TIMEOUT_LOG2  idle cycles before a held partial packet is closed; 0 disables flush
- i_tdata/i_tlast/i_tvalid/i_tready  in/in/in/out  WIDTH/1/1/1  input AXI-Stream
- o_tdata/o_tlast/o_tvalid/o_tready  out/out/out/in  WIDTH/1/1/1  output AXI-Stream
- pkt_count  out  16  number of output beats transferred with o_tlast=1; wraps at 65535

Behaviour:
- Reset or clear:
  - o_tvalid=0, o_tdata=0, o_tlast=0.
  - spp_count=0, idle_cnt=0, pkt_count=0 (clear also zeroes pkt_count), state EMPTY.
  - Any held or presented sample is discarded.
- AXI rules:
  - A beat transfers when valid & ready.
  - Once asserted, o_tvalid holds with o_tdata/o_tlast stable until transfer. The only exception is HOLD, defined under the optional feature.
- Output stage:
  - One register stage; latency 1 cycle from input transfer to o_tvalid.
  - Full throughput: i_tready = ~o_tvalid | o_tready.
- tlast decision, made when a sample is accepted:
  - eff_spp = (max_spp==0) ? 1 : max_spp.
  - last = (spp_count+1 >= eff_spp) | (honor_tlast & i_tlast).
  - Compare at MAX_LEN_LOG2+1 bits to avoid wrap.
  - The >= comparison means that lowering max_spp mid-packet closes the packet on the next sample.
- spp_count:
  - Reset to 0 when the accepted sample carries last=1.
  - Otherwise increments on every accepted sample.
  - max_spp is sampled each beat; there is no latching.
- pkt_count increments on each output transfer with o_tlast=1.
- States without the feature:
  - EMPTY: o_tvalid=0. Moves to PRESENT on input transfer.
  - PRESENT: o_tvalid=1.
    - On output transfer with a simultaneous input transfer, load the new sample and stay in PRESENT.
    - On output transfer without an input transfer, go to EMPTY.
- Reset asserted mid-packet: the partial packet is lost. The next packet starts at spp_count=0.

Optional Feature:
- Macro: STREAM_REFRAMER_IDLE_FLUSH_EN.
- With the macro defined, a third state HOLD is added:
  - A sample accepted with last=0 enters HOLD, not PRESENT.
  - In HOLD: o_tvalid = i_tvalid (combinational), o_tlast=0, i_tready = o_tready.
  - A transfer in HOLD emits the held sample and loads the incoming one, which goes to HOLD or PRESENT per its last decision.
  - A sample accepted with last=1 goes to PRESENT.
  - idle_cnt counts cycles in HOLD with i_tvalid=0 and resets on any i_tvalid.
  - When idle_cnt reaches idle_timeout (idle_timeout≠0): set o_tlast=1, set spp_count=0, go to PRESENT.
  - idle_timeout=0: the sample is held indefinitely.
  - Latency for samples with undecided tlast equals the arrival of the next sample or the timeout.
- Without the macro: no HOLD state and no idle_cnt logic. idle_timeout is ignored.

Test Plan:
- max_spp=4, honor_tlast=0, 10 back-to-back samples 0..9, o_tready=1 → tlast on samples 3 and 7; 8,9 follow with tlast=0; pkt_count=2; one beat per cycle after 1-cycle latency.
- max_spp=8, honor_tlast=1, i_tlast on sample 2 of a 12-sample stream → tlast on samples 2 and 10; spp_count restarts after 2.
- max_spp=0 → every output beat has tlast=1; pkt_count equals the beat count.
- o_tready toggled on a random pattern with max_spp=5 and 20 samples → data order preserved; tlast on samples 4, 9, 14, 19; o_tdata stable while stalled.
- max_spp=16, 3 samples sent, then clear pulsed → o_tvalid=0 the next cycle; the following stream's first tlast comes at its 16th sample; pkt_count=0.
- With STREAM_REFRAMER_IDLE_FLUSH_EN, idle_timeout=5, max_spp=16, 3 samples then idle → sample 2 is presented with tlast=1 five cycles after the last input; pkt_count=1. With idle_timeout=0 → sample 2 is never presented.

Source files
------------

// File: rtl/stream_reframer_if.sv
// AXI-Stream beat bundle shared by the reframer's input and output sides.
interface stream_reframer_if #(
   parameter int unsigned WIDTH = 16
) ();
   logic [WIDTH-1:0] tdata;
   logic             tlast;
   logic             tvalid;
   logic             tready;

   modport master (output tdata, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/stream_reframer.sv
// Rebuilds AXI-Stream packet framing: tlast every max_spp samples and optionally at upstream tlast.
// Define STREAM_REFRAMER_IDLE_FLUSH_EN to hold the newest sample and close idle partial packets.
module stream_reframer #(
   parameter int unsigned MAX_LEN_LOG2 = 10,
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned TIMEOUT_LOG2 = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_i,
   input  logic [MAX_LEN_LOG2-1:0] max_spp_i,
   input  logic                    honor_tlast_i,
   input  logic [TIMEOUT_LOG2-1:0] idle_timeout_i,
   stream_reframer_if.slave        in_if,
   stream_reframer_if.master       out_if,
   output logic [15:0]             pkt_count_o
);

`ifdef STREAM_REFRAMER_IDLE_FLUSH_EN
   typedef enum logic [1:0] {StEmpty, StPresent, StHold} state_e;
`else
   typedef enum logic [1:0] {StEmpty, StPresent} state_e;
`endif

   state_e                  state_q, state_d, accept_st;
   logic [WIDTH-1:0]        data_q, data_d;
   logic                    last_q, last_d;
   logic [MAX_LEN_LOG2-1:0] spp_q, spp_d;
   logic [15:0]             pkt_q, pkt_d;

   logic [MAX_LEN_LOG2:0]   eff_spp, spp_next;
   logic                    last_dec;
   logic                    o_tvalid, o_tlast, i_tready;
   logic                    in_xfer, out_xfer;

`ifdef STREAM_REFRAMER_IDLE_FLUSH_EN
   logic [TIMEOUT_LOG2-1:0] idle_q, idle_d;
   logic [TIMEOUT_LOG2:0]   idle_next;
`else
   logic unused_idle_timeout;
   assign unused_idle_timeout = ^idle_timeout_i;
`endif

   // Extra bit keeps spp_count+1 from wrapping when compared against eff_spp.
   always_comb begin
      eff_spp  = (max_spp_i == '0) ? (MAX_LEN_LOG2+1)'(1) : {1'b0, max_spp_i};
      spp_next = {1'b0, spp_q} + (MAX_LEN_LOG2+1)'(1);
      last_dec = (spp_next >= eff_spp) | (honor_tlast_i & in_if.tlast);
`ifdef STREAM_REFRAMER_IDLE_FLUSH_EN
      accept_st = last_dec ? StPresent : StHold;
`else
      accept_st = StPresent;
`endif
   end

   always_comb begin
      o_tvalid = (state_q == StPresent);
      o_tlast  = last_q;
      i_tready = ~o_tvalid | out_if.tready;
`ifdef STREAM_REFRAMER_IDLE_FLUSH_EN
      // Held sample is released only alongside the next incoming one.
      if (state_q == StHold) begin
         o_tvalid = in_if.tvalid;
         o_tlast  = 1'b0;
         i_tready = out_if.tready;
      end
`endif
   end

   assign in_xfer  = in_if.tvalid & i_tready;
   assign out_xfer = o_tvalid & out_if.tready;

   assign in_if.tready  = i_tready;
   assign out_if.tvalid = o_tvalid;
   assign out_if.tlast  = o_tlast;
   assign out_if.tdata  = data_q;
   assign pkt_count_o   = pkt_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      last_d  = last_q;
      spp_d   = spp_q;
      pkt_d   = pkt_q;
`ifdef STREAM_REFRAMER_IDLE_FLUSH_EN
      idle_d    = '0;
      idle_next = {1'b0, idle_q} + (TIMEOUT_LOG2+1)'(1);
`endif
      if (out_xfer && o_tlast) pkt_d = pkt_q + 16'd1;
      if (in_xfer) begin
         data_d = in_if.tdata;
         last_d = last_dec;
         spp_d  = last_dec ? '0 : spp_next[MAX_LEN_LOG2-1:0];
      end
      unique case (state_q)
         StEmpty: begin
            if (in_xfer) state_d = accept_st;
         end
         StPresent: begin
            if (in_xfer)       state_d = accept_st;
            else if (out_xfer) state_d = StEmpty;
         end
`ifdef STREAM_REFRAMER_IDLE_FLUSH_EN
         StHold: begin
            if (in_xfer) begin
               state_d = accept_st;
            end else if (!in_if.tvalid) begin
               if (idle_timeout_i != '0 && idle_next >= {1'b0, idle_timeout_i}) begin
                  last_d  = 1'b1;
                  spp_d   = '0;
                  state_d = StPresent;
               end else begin
                  idle_d = idle_next[TIMEOUT_LOG2-1:0];
               end
            end
         end
`endif
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         state_q <= StEmpty;
         data_q  <= '0;
         last_q  <= 1'b0;
         spp_q   <= '0;
         pkt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         last_q  <= last_d;
         spp_q   <= spp_d;
         pkt_q   <= pkt_d;
      end
   end

`ifdef STREAM_REFRAMER_IDLE_FLUSH_EN
   always_ff @(posedge clk) begin
      if (reset || clear_i) idle_q <= '0;
      else                  idle_q <= idle_d;
   end
`endif

endmodule

// File: tb/tb_stream_reframer.sv
// Self-checking bench for stream_reframer: framing vectors, corner sequences and random traffic.
module tb_stream_reframer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic [9:0]  max_spp = 10'd4;
   logic        honor = 1'b0;
   logic [7:0]  idle_timeout = 8'd0;
   logic [15:0] pkt_count;

   stream_reframer_if #(.WIDTH(16)) in_if ();
   stream_reframer_if #(.WIDTH(16)) out_if ();

   stream_reframer dut (
      .clk            (clk),
      .reset          (reset),
      .clear_i        (clear),
      .max_spp_i      (max_spp),
      .honor_tlast_i  (honor),
      .idle_timeout_i (idle_timeout),
      .in_if          (in_if),
      .out_if         (out_if),
      .pkt_count_o    (pkt_count)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Beat log filled by the monitor; spp records max_spp at acceptance time.
   typedef struct {
      logic [15:0] d;
      logic        l;
      int unsigned c;
      int unsigned spp;
   } beat_t;

   beat_t       acc_q[$];
   beat_t       obs_q[$];
   int unsigned cyc = 0;
   logic        stall_prev = 1'b0;
   logic [15:0] stall_d = '0;
   logic        stall_l = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && !clear) begin
         if (in_if.tvalid && in_if.tready)
            acc_q.push_back('{in_if.tdata, in_if.tlast, cyc, 32'(max_spp)});
         if (out_if.tvalid && out_if.tready)
            obs_q.push_back('{out_if.tdata, out_if.tlast, cyc, 32'(max_spp)});
         if (stall_prev)
            check("stall stable", {15'd0, out_if.tvalid, out_if.tlast, out_if.tdata},
                  {15'd0, 1'b1, stall_l, stall_d});
      end
      stall_prev <= out_if.tvalid && !out_if.tready && !reset && !clear;
      stall_d    <= out_if.tdata;
      stall_l    <= out_if.tlast;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      acc_q.delete();
      obs_q.delete();
   endtask

   task automatic send_stream(input int n, input int tlast_at, input logic rnd_ready);
      int   i = 0;
      int   guard = 0;
      logic acc;
      in_if.tvalid = 1'b1;
      in_if.tdata  = 16'(0);
      in_if.tlast  = (tlast_at == 0);
      while (i < n && guard < 2000) begin
         out_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         acc = in_if.tvalid && in_if.tready;
         step();
         if (acc) begin
            i++;
            in_if.tdata = 16'(i);
            in_if.tlast = (i == tlast_at);
         end
         guard++;
      end
      if (i < n) check("send timeout", 32'(i), 32'(n));
      in_if.tvalid  = 1'b0;
      in_if.tlast   = 1'b0;
      out_if.tready = 1'b1;
   endtask

   task automatic drain(input int unsigned n);
      int g = 0;
      out_if.tready = 1'b1;
      while (obs_q.size() < n && g < 200) begin
         step();
         g++;
      end
      repeat (2) step();
   endtask

   typedef struct {
      int unsigned spp;
      logic        honor;
      int          n;
      int          tlast_at;
      logic        rnd;
      int unsigned exp_pkts;
      logic [31:0] last_mask;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [31:0] mask;
      int unsigned pkts;
      int unsigned nb;
      logic        seen;

      vecs[0] = '{4, 1'b0, 10, -1, 1'b0, 2, 32'h0000_0088};
      vecs[1] = '{8, 1'b1, 12, 2, 1'b0, 2, 32'h0000_0404};
      vecs[2] = '{0, 1'b0, 6, -1, 1'b0, 6, 32'h0000_003F};
      vecs[3] = '{5, 1'b0, 20, -1, 1'b1, 4, 32'h0008_4210};
      vecs[4] = '{3, 1'b0, 7, 1, 1'b0, 2, 32'h0000_0024};

      in_if.tvalid  = 1'b0;
      in_if.tdata   = '0;
      in_if.tlast   = 1'b0;
      out_if.tready = 1'b1;
      repeat (3) step();
      check("rst tvalid", 32'(out_if.tvalid), 32'd0);
      check("rst tdata", 32'(out_if.tdata), 32'd0);
      check("rst tlast", 32'(out_if.tlast), 32'd0);
      check("rst pkt_count", 32'(pkt_count), 32'd0);
      check("rst i_tready", 32'(in_if.tready), 32'd1);
      reset = 1'b0;
      step();

`ifdef STREAM_REFRAMER_IDLE_FLUSH_EN
      idle_timeout = 8'd3;
`endif
      for (int v = 0; v < 5; v++) begin
         max_spp = 10'(vecs[v].spp);
         honor   = vecs[v].honor;
         do_clear();
         check("clear pkt_count", 32'(pkt_count), 32'd0);
         mask = vecs[v].last_mask;
         pkts = vecs[v].exp_pkts;
`ifdef STREAM_REFRAMER_IDLE_FLUSH_EN
         if (!mask[vecs[v].n-1]) begin
            mask[vecs[v].n-1] = 1'b1;
            pkts++;
         end
`endif
         send_stream(vecs[v].n, vecs[v].tlast_at, vecs[v].rnd);
         drain(32'(vecs[v].n));
         check($sformatf("vec%0d beats", v), 32'(obs_q.size()), 32'(vecs[v].n));
         for (int k = 0; k < obs_q.size() && k < vecs[v].n; k++) begin
            check($sformatf("vec%0d data[%0d]", v, k), 32'(obs_q[k].d), 32'(k));
            check($sformatf("vec%0d last[%0d]", v, k), 32'(obs_q[k].l), 32'(mask[k]));
         end
         check($sformatf("vec%0d pkt_count", v), 32'(pkt_count), pkts);
`ifndef STREAM_REFRAMER_IDLE_FLUSH_EN
         if (!vecs[v].rnd && obs_q.size() == vecs[v].n && acc_q.size() > 0)
            check($sformatf("vec%0d span", v), obs_q[vecs[v].n-1].c - acc_q[0].c,
                  32'(vecs[v].n));
`endif
      end

      // Clear mid-packet: partial packet lost, counting restarts at zero.
      max_spp = 10'd16;
      honor   = 1'b0;
      do_clear();
      send_stream(3, -1, 1'b0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr tvalid", 32'(out_if.tvalid), 32'd0);
      check("clr pkt_count", 32'(pkt_count), 32'd0);
      acc_q.delete();
      obs_q.delete();
      send_stream(16, -1, 1'b0);
      drain(16);
      check("clr beats", 32'(obs_q.size()), 32'd16);
      nb = 0;
      for (int k = 0; k < obs_q.size(); k++) if (obs_q[k].l) nb++;
      check("clr lasts", 32'(nb), 32'd1);
      if (obs_q.size() == 16) check("clr last idx15", 32'(obs_q[15].l), 32'd1);
      check("clr pkt after", 32'(pkt_count), 32'd1);

`ifdef STREAM_REFRAMER_IDLE_FLUSH_EN
      // Idle flush of a held partial packet.
      idle_timeout = 8'd5;
      do_clear();
      for (int k = 0; k < 3; k++) begin
         in_if.tvalid = 1'b1;
         in_if.tdata  = 16'(k);
         in_if.tlast  = 1'b0;
         step();
      end
      in_if.tvalid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("flush early %0d", k), 32'(out_if.tvalid), 32'd0);
      end
      step();
      check("flush tvalid", 32'(out_if.tvalid), 32'd1);
      check("flush tdata", 32'(out_if.tdata), 32'd2);
      check("flush tlast", 32'(out_if.tlast), 32'd1);
      step();
      check("flush pkt_count", 32'(pkt_count), 32'd1);
      check("flush done", 32'(out_if.tvalid), 32'd0);

      idle_timeout = 8'd0;
      do_clear();
      send_stream(3, -1, 1'b0);
      seen = 1'b0;
      repeat (40) begin
         step();
         seen = seen | out_if.tvalid;
      end
      check("hold forever tvalid", 32'(seen), 32'd0);
      check("hold forever beats", 32'(obs_q.size()), 32'd2);
`endif

      // Random traffic against a packet-counting model.
      begin
         int          sent = 0;
         int          guard = 0;
         logic        acc;
         int unsigned cnt = 0;
         int unsigned eff;
         int unsigned exp_n;
         logic        exp_l[$];

         idle_timeout = 8'd0;
         honor   = 1'b1;
         max_spp = 10'($urandom_range(0, 6));
         do_clear();
         while (sent < 300 && guard < 5000) begin
            if (!in_if.tvalid && $urandom_range(0, 3) != 0) begin
               in_if.tvalid = 1'b1;
               in_if.tdata  = 16'($urandom);
               in_if.tlast  = ($urandom_range(0, 4) == 0);
            end
            out_if.tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_if.tvalid && in_if.tready;
            step();
            if (acc) begin
               sent++;
               in_if.tvalid = 1'b0;
            end
            if (guard % 37 == 36) max_spp = 10'($urandom_range(0, 6));
            guard++;
         end
         in_if.tvalid = 1'b0;
         check("rnd sent", 32'(sent), 32'd300);
         drain(32'(acc_q.size()));

         foreach (acc_q[k]) begin
            eff = (acc_q[k].spp == 0) ? 1 : acc_q[k].spp;
            exp_l.push_back((cnt + 1 >= eff) || acc_q[k].l);
            cnt = exp_l[k] ? 0 : cnt + 1;
         end
         exp_n = acc_q.size();
`ifdef STREAM_REFRAMER_IDLE_FLUSH_EN
         if (exp_n > 0 && !exp_l[exp_n-1]) exp_n--;
`endif
         check("rnd beats", 32'(obs_q.size()), exp_n);
         pkts = 0;
         for (int k = 0; k < obs_q.size() && k < exp_n; k++) begin
            check($sformatf("rnd beat %0d", k), {15'd0, obs_q[k].l, obs_q[k].d},
                  {15'd0, exp_l[k], acc_q[k].d});
            if (exp_l[k]) pkts++;
         end
         check("rnd pkt_count", 32'(pkt_count), pkts & 32'hFFFF);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
